rvcpu_mem_arbiter: RTL
======================

// Module: rvcpu_mem_arbiter
// PURPOSE
//   Shares one single-port synchronous memory (1-cycle read latency) between the CPU
//   instruction-fetch port and the load/store data port.
//   Accepts at most one request per cycle and returns read data one cycle later to the
//   port that issued it. Bounds fetch starvation and counts conflict cycles.
//   Sits between the RVCPU core and the unified instruction/data RAM.
// PARAMETERS
//   AW        32  byte-address width on all ports
//   DW        32  data width; byte enables are DW/8 bits
//   MAX_WAIT  4   consecutive fetch denials tolerated before fetch is forced to win (1..15)
// PORTS
//   clk            in   1       clock; all logic on the rising edge
//   rst            in   1       synchronous, active-high reset
//   if_req         in   1       fetch request; addr held stable until if_gnt
//   if_addr        in   AW      fetch byte address
//   if_gnt         out  1       fetch accepted this cycle (combinational)
//   if_rvalid      out  1       if_rdata valid (cycle after grant)
//   if_rdata       out  DW      fetched word
//   d_req          in   1       data request; d_* held stable until d_gnt
//   d_we           in   1       1 = store, 0 = load
//   d_be           in   DW/8    store byte enables (ignored for loads)
//   d_addr         in   AW      data byte address
//   d_wdata        in   DW      store data
//   d_gnt          out  1       data request accepted this cycle (combinational)
//   d_rvalid       out  1       d_rdata valid (loads only, cycle after grant)
//   d_rdata        out  DW      load word
//   mem_en         out  1       memory access strobe
//   mem_we         out  DW/8    byte write enables (all 0 on reads)
//   mem_addr       out  AW-2    word address = granted addr[AW-1:2]
//   mem_wdata      out  DW      write data
//   mem_rdata      in   DW      read data, valid the cycle after mem_en with mem_we==0
//   perf_conflicts out  32      cycles with if_req & d_req both high; saturates at 0xFFFFFFFF
// BEHAVIOUR
//   - Reset values: if_rvalid=0, d_rvalid=0, perf_conflicts=0, starve counter=0, owner=NONE.
//     Gnt/mem_* outputs are 0 while rst=1.
//   - Grant (combinational, same cycle):
//     - only one requester -> it wins;
//     - both -> data wins unless starve_cnt==MAX_WAIT, then fetch wins.
//   - Exactly one of if_gnt/d_gnt may be high per cycle; mem_en = if_gnt|d_gnt.
//   - Memory drive on a grant:
//     - mem_addr/mem_wdata from the winner;
//     - mem_we = d_be if a data store is granted, else 0.
//   - Owner register (NONE/IF/D): on the edge after a read grant it holds the reader.
//     The next cycle asserts that port's rvalid for exactly one cycle; rdata = mem_rdata.
//     Stores and no-grant cycles set owner=NONE.
//   - Back-to-back grants every cycle are allowed; owner tracking is pipelined.
//     Throughput is 1 access/cycle and read latency is 1.
//   - if_rdata/d_rdata are driven from mem_rdata; they are don't-care when rvalid=0.
//   - starve_cnt:
//     - +1 on a cycle with if_req & !if_gnt;
//     - cleared on if_gnt or when if_req=0;
//     - never exceeds MAX_WAIT.
//   - perf_conflicts: +1 on each cycle with both requests high; holds at max.
//   - Reset mid-read: owner cleared, no rvalid is issued for the in-flight read,
//     and the pending request must be re-presented.
//   - Request dropped before grant: legal; nothing is issued.
// STRUCTURE
//   - rvcpu_pkg holds: AW/DW defaults, the owner enum (OWN_NONE=2'd0, OWN_IF=2'd1,
//     OWN_D=2'd2), and MAX_WAIT_DEF.
//   - Sub-module rvcpu_arb_pick: pure combinational priority pick.
//     Inputs: if_req, d_req, force_if. Outputs: the one-hot grant.
//   - Top holds the owner register, starve counter, perf counter and mem muxing.
// TESTING
//   1. Reset: hold rst 2 cycles with requests high -> no gnt, mem_en=0, all rvalid=0,
//      perf_conflicts=0.
//   2. Lone fetch if_addr=0x10, mem word 4 = 0x00500093 -> if_gnt same cycle,
//      mem_addr=4, next cycle if_rvalid=1 and if_rdata=0x00500093.
//   3. Store d_addr=0x20, d_be=4'b0011, d_wdata=0xAABBCCDD -> d_gnt, mem_we=0011,
//      mem_addr=8, no d_rvalid. A following load of 0x20 returns 0x0000CCDD
//      (memory pre-zeroed).
//   4. Both requesting continuously, MAX_WAIT=4 -> grant order D,D,D,D,IF,D,...;
//      perf_conflicts counts every cycle.
//   5. Back-to-back: fetch load, data load, fetch load on consecutive cycles ->
//      rvalids alternate IF,D,IF on the following cycles with correct data and no gaps.
//   6. rst asserted the cycle after a fetch read grant -> no if_rvalid;
//      normal service resumes after rst drops.

Source files
------------

// File: rtl/rvcpu_pkg.sv
// Shared types and defaults for the RVCPU memory arbiter slice.
package rvcpu_pkg;

  localparam int AW_DEF       = 32;
  localparam int DW_DEF       = 32;
  localparam int MAX_WAIT_DEF = 4;

  // Which port the read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/rvcpu_arb_pick.sv
// Combinational priority pick between fetch and data requests.
// Data normally wins a tie; force_if hands the tie to fetch instead.
module rvcpu_arb_pick (
  input  logic if_req,
  input  logic d_req,
  input  logic force_if,
  output logic if_gnt,
  output logic d_gnt
);

  // One-hot grant: at most one of if_gnt/d_gnt is ever high.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (if_req && (!d_req || force_if)) begin
      if_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/rvcpu_mem_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle read latency) between
// the instruction-fetch port and the load/store port.
//
// Handshake: a port raises *_req with its address/data stable; the request
// is accepted in the same cycle *_gnt is high (req & gnt = transfer). The
// requester must hold its fields until that cycle, or may drop req before
// it. For a granted read, *_rvalid is high for exactly one cycle on the
// following cycle with *_rdata valid; there is no backpressure on rvalid.
module rvcpu_mem_arbiter
  import rvcpu_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-3:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [31:0]     perf_conflicts,
  output owner_e          dbg_owner
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  owner_e     owner_q;
  owner_e     owner_d;
  logic [3:0] starve_cnt;
  logic       if_req_ok;
  logic       d_req_ok;
  logic       force_if;

  // Byte-offset bits do not select anything in a word-wide memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  // Nothing is granted while reset is held.
  assign if_req_ok = if_req & ~rst;
  assign d_req_ok  = d_req & ~rst;
  assign force_if  = (starve_cnt == MAX_WAIT_C);

  rvcpu_arb_pick u_pick (
    .if_req   (if_req_ok),
    .d_req    (d_req_ok),
    .force_if (force_if),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt)
  );

  // Route the winner onto the memory port; idle drives all zeros.
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr[AW-1:2];
    end else if (d_gnt) begin
      mem_addr  = d_addr[AW-1:2];
      mem_wdata = d_wdata;
      if (d_we) begin
        mem_we = d_be;
      end
    end
  end

  // Owner register: remembers who issued the read now in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Next owner: reader of this cycle's grant, NONE for stores and idle.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
  end

  // A read caught by reset is dropped, so rvalid is masked during reset.
  assign if_rvalid = (owner_q == OWN_IF) & ~rst;
  assign d_rvalid  = (owner_q == OWN_D) & ~rst;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign dbg_owner = owner_q;

  // Starvation counter: consecutive cycles fetch waited behind data.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != MAX_WAIT_C) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Conflict counter: cycles with both ports requesting, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflicts <= '0;
    end else if (if_req && d_req && (perf_conflicts != 32'hFFFF_FFFF)) begin
      perf_conflicts <= perf_conflicts + 32'd1;
    end
  end

endmodule
